// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single mem_space port (MAB_out/MDB_to_mem/MW/BW) between a CPU
//   requester (port c) and a DMA requester (port d). Round-robin arbitration,
//   one transaction owns the bus at a time. Reads take one bus cycle, writes
//   hold MW until ram_write_done or a timeout, and writes outside RAM are
//   rejected with an error and never strobe MW.
//
// Ports
//   clk, rst_n                 clock and asynchronous active-low reset
//   c_req/c_we/c_bw/c_addr/c_wdata   CPU request and attributes
//   d_req/d_we/d_bw/d_addr/d_wdata   DMA request and attributes
//   c_ack/c_err/c_rdata        CPU one-cycle completion pulse, error, read data
//   d_ack/d_err/d_rdata        DMA one-cycle completion pulse, error, read data
//   MAB_out/MDB_to_mem/MW/BW   address, write data, write strobe, byte qualifier
//   MDB_from_mem               read data from mem_space (combinational on MAB_out)
//   ram_write_done             RAM write completion
module mem_bus_arbiter #(
  parameter logic [15:0] RAM_LO     = 16'h0200,
  parameter logic [15:0] RAM_HI     = 16'h0400,
  parameter int unsigned WR_TIMEOUT = 15,
  parameter int unsigned TO_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_we,
  input  logic        c_bw,
  input  logic [15:0] c_addr,
  input  logic [15:0] c_wdata,
  output logic        c_ack,
  output logic        c_err,
  output logic [15:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_bw,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [15:0] d_rdata,
  output logic [15:0] MAB_out,
  output logic [15:0] MDB_to_mem,
  output logic        MW,
  output logic        BW,
  input  logic [15:0] MDB_from_mem,
  input  logic        ram_write_done
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  // Counter value on the last permitted WRITE cycle.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(WR_TIMEOUT - 1);

  state_t          state;
  logic            gnt_d;       // 1: current transaction belongs to DMA
  logic            last_gnt_d;  // 1: DMA was granted most recently
  logic [TO_W-1:0] to_cnt;

  logic            pick_d;
  logic            any_req;
  logic            sel_we;
  logic            sel_bw;
  logic [15:0]     sel_addr;
  logic [15:0]     sel_wdata;
  logic            sel_in_ram;

  // Arbitration and selection of the candidate transaction. With both ports
  // requesting, the port that did not win last time is chosen. Word accesses
  // are aligned here so the RAM range check sees the address actually driven.
  always_comb begin
    any_req = c_req | d_req;
    if (c_req && d_req) begin
      pick_d = ~last_gnt_d;
    end else begin
      pick_d = d_req;
    end
    sel_we    = pick_d ? d_we    : c_we;
    sel_bw    = pick_d ? d_bw    : c_bw;
    sel_addr  = pick_d ? d_addr  : c_addr;
    sel_wdata = pick_d ? d_wdata : c_wdata;
    if (!sel_bw) begin
      sel_addr[0] = 1'b0;
    end
    sel_in_ram = (sel_addr >= RAM_LO) && (sel_addr < RAM_HI);
  end

  // Transaction FSM. All bus and response outputs are registered here; ack
  // and err are raised on entry to RESP and cleared on leaving it, so they
  // are exactly one cycle wide. MAB_out is only updated when a transaction
  // actually drives the bus, so it holds its last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_d      <= 1'b0;
      last_gnt_d <= 1'b1;
      to_cnt     <= '0;
      MAB_out    <= '0;
      MDB_to_mem <= '0;
      MW         <= 1'b0;
      BW         <= 1'b0;
      c_ack      <= 1'b0;
      c_err      <= 1'b0;
      c_rdata    <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          MW <= 1'b0;
          if (any_req) begin
            gnt_d      <= pick_d;
            last_gnt_d <= pick_d;
            if (!sel_we) begin
              MAB_out <= sel_addr;
              state   <= READ;
            end else if (sel_in_ram) begin
              MAB_out    <= sel_addr;
              MDB_to_mem <= sel_wdata;
              BW         <= sel_bw;
              MW         <= 1'b1;
              to_cnt     <= '0;
              state      <= WRITE;
            end else begin
              // Rejected write: respond straight away, bus untouched.
              if (pick_d) begin
                d_ack <= 1'b1;
                d_err <= 1'b1;
              end else begin
                c_ack <= 1'b1;
                c_err <= 1'b1;
              end
              state <= RESP;
            end
          end
        end

        READ: begin
          if (gnt_d) begin
            d_rdata <= MDB_from_mem;
            d_ack   <= 1'b1;
            d_err   <= 1'b0;
          end else begin
            c_rdata <= MDB_from_mem;
            c_ack   <= 1'b1;
            c_err   <= 1'b0;
          end
          state <= RESP;
        end

        WRITE: begin
          // Completion takes priority over a timeout on the same edge.
          if (ram_write_done || (to_cnt == TO_LAST)) begin
            MW     <= 1'b0;
            BW     <= 1'b0;
            to_cnt <= '0;
            if (gnt_d) begin
              d_ack <= 1'b1;
              d_err <= ~ram_write_done;
            end else begin
              c_ack <= 1'b1;
              c_err <= ~ram_write_done;
            end
            state <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        RESP: begin
          c_ack  <= 1'b0;
          c_err  <= 1'b0;
          d_ack  <= 1'b0;
          d_err  <= 1'b0;
          to_cnt <= '0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
